unidade_acesso_memoria: RTL and testbench

UNIDADE_ACESSO_MEMORIA -- requirements
Module: unidade_acesso_memoria

---
 rtl/unidade_acesso_memoria.sv | 81 ++++++++
 tb/tb_unidade_acesso_memoria.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_acesso_memoria.sv
// Memory access unit: accepts one load/store from the pipeline and sequences the data-memory access.
// Store done 1 cycle after acceptance, load response valid 2 cycles after; ReqPronto low while busy, response held until RespPronto.
module unidade_acesso_memoria (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       ReqValido,
   input  logic       ReqEscrita,
   input  logic [7:0] ReqEndereco,
   input  logic [7:0] ReqDado,
   output logic       ReqPronto,
   output logic       RespValido,
   output logic [7:0] RespDado,
   input  logic       RespPronto,
   output logic [7:0] Endereco,
   output logic [7:0] DadoEscrito,
   output logic       EscMem,
   output logic       LerMem,
   input  logic [7:0] DadoLido,
   input  logic       ZeraCont,
   output logic [7:0] ContEscritas,
   output logic [7:0] ContLeituras
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESCREVE  = 2'd1,
      LE       = 2'd2,
      RESPOSTA = 2'd3
   } estado_t;

   estado_t estado;

   // Strobes come straight from the state register so an async reset drops them at once.
   assign ReqPronto  = (estado == OCIOSO);
   assign EscMem     = (estado == ESCREVE);
   assign LerMem     = (estado == LE);
   assign RespValido = (estado == RESPOSTA);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado       <= OCIOSO;
         Endereco     <= 8'h00;
         DadoEscrito  <= 8'h00;
         RespDado     <= 8'h00;
         ContEscritas <= 8'h00;
         ContLeituras <= 8'h00;
      end else begin
         case (estado)
            OCIOSO: begin
               if (ReqValido) begin
                  Endereco    <= ReqEndereco;
                  DadoEscrito <= ReqDado;
                  estado      <= ReqEscrita ? ESCREVE : LE;
               end
            end
            ESCREVE: estado <= OCIOSO;
            LE: begin
               // DadoLido was refreshed by the memory on the falling edge inside LE.
               RespDado <= DadoLido;
               estado   <= RESPOSTA;
            end
            RESPOSTA: begin
               if (RespPronto)
                  estado <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase

         if (ZeraCont) begin
            ContEscritas <= 8'h00;
            ContLeituras <= 8'h00;
         end else begin
            if (estado == ESCREVE && ContEscritas != 8'hFF)
               ContEscritas <= ContEscritas + 8'd1;
            if (estado == LE && ContLeituras != 8'hFF)
               ContLeituras <= ContLeituras + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Directed bench for unidade_acesso_memoria with a behavioural data memory and a reference image of its contents.
module tb_unidade_acesso_memoria;

   logic       Clock = 1'b0;
   logic       Reset_n;
   logic       ReqValido, ReqEscrita;
   logic [7:0] ReqEndereco, ReqDado;
   logic       ReqPronto, RespValido, RespPronto;
   logic [7:0] RespDado, Endereco, DadoEscrito, DadoLido;
   logic       EscMem, LerMem, ZeraCont;
   logic [7:0] ContEscritas, ContLeituras;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   always #5 Clock = ~Clock;

   unidade_acesso_memoria dut (
      .Clock        (Clock),
      .Reset_n      (Reset_n),
      .ReqValido    (ReqValido),
      .ReqEscrita   (ReqEscrita),
      .ReqEndereco  (ReqEndereco),
      .ReqDado      (ReqDado),
      .ReqPronto    (ReqPronto),
      .RespValido   (RespValido),
      .RespDado     (RespDado),
      .RespPronto   (RespPronto),
      .Endereco     (Endereco),
      .DadoEscrito  (DadoEscrito),
      .EscMem       (EscMem),
      .LerMem       (LerMem),
      .DadoLido     (DadoLido),
      .ZeraCont     (ZeraCont),
      .ContEscritas (ContEscritas),
      .ContLeituras (ContLeituras)
   );

   // Data memory: write on rising edge, read data refreshed on falling edge.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      DadoLido = 8'h00;
   end
   always @(posedge Clock) if (EscMem) mem[Endereco] <= DadoEscrito;
   always @(negedge Clock) if (LerMem) DadoLido <= mem[Endereco];

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, esp, $time);
      end
   endtask

   always @(negedge Clock) if (Reset_n) verifica("exclusivo", {31'd0, EscMem & LerMem}, 0);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   task automatic armazena(input logic [7:0] a, input logic [7:0] d, input logic zera);
      ReqValido = 1'b1; ReqEscrita = 1'b1; ReqEndereco = a; ReqDado = d;
      @(posedge Clock); #1;
      ReqValido = 1'b0; ReqEndereco = ~a; ReqDado = ~d; ZeraCont = zera;
      verifica("esc_escmem", EscMem, 1);
      verifica("esc_end", Endereco, a);
      verifica("esc_dado", DadoEscrito, d);
      verifica("esc_pronto", ReqPronto, 0);
      ref_mem[a] = d;
      @(posedge Clock); #1;
      ZeraCont = 1'b0;
      verifica("esc_fim", EscMem, 0);
      verifica("esc_pronto2", ReqPronto, 1);
   endtask

   task automatic le(input logic [7:0] a, input int espera);
      logic [7:0] esp;
      esp = ref_mem[a];
      ReqValido = 1'b1; ReqEscrita = 1'b0; ReqEndereco = a; ReqDado = 8'h3C;
      @(posedge Clock); #1;
      ReqValido = 1'b0; ReqEndereco = ~a;
      verifica("le_lermem", LerMem, 1);
      verifica("le_escmem", EscMem, 0);
      verifica("le_resp_cedo", RespValido, 0);
      verifica("le_end", Endereco, a);
      @(posedge Clock); #1;
      verifica("le_lermem_fim", LerMem, 0);
      verifica("le_respvalido", RespValido, 1);
      verifica("le_respdado", RespDado, esp);
      for (int k = 0; k < espera; k++) begin
         ReqValido = 1'b1; ReqEscrita = 1'b1; ReqEndereco = 8'h33; ReqDado = 8'hEE;
         RespPronto = 1'b0;
         @(posedge Clock); #1;
         verifica("hold_valido", RespValido, 1);
         verifica("hold_dado", RespDado, esp);
         verifica("hold_pronto", ReqPronto, 0);
         verifica("hold_escmem", EscMem, 0);
      end
      ReqValido = 1'b0; RespPronto = 1'b1;
      @(posedge Clock); #1;
      RespPronto = 1'b0;
      verifica("le_liberado", RespValido, 0);
      verifica("le_pronto", ReqPronto, 1);
   endtask

   initial begin
      logic [7:0] a, d;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      Reset_n = 1'b0; ReqValido = 1'b0; ReqEscrita = 1'b0; ReqEndereco = 8'h00;
      ReqDado = 8'h00; RespPronto = 1'b0; ZeraCont = 1'b0;
      #3;
      verifica("rst_pronto", ReqPronto, 1);
      verifica("rst_escmem", EscMem, 0);
      verifica("rst_lermem", LerMem, 0);
      verifica("rst_respvalido", RespValido, 0);
      verifica("rst_end", Endereco, 0);
      verifica("rst_dado", DadoEscrito, 0);
      verifica("rst_respdado", RespDado, 0);
      verifica("rst_contesc", ContEscritas, 0);
      verifica("rst_contlei", ContLeituras, 0);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      @(posedge Clock); #1;
      verifica("ocioso_end", Endereco, 0);

      armazena(8'h10, 8'hA5, 1'b0);
      verifica("cont_esc_1", ContEscritas, 1);
      le(8'h10, 0);
      verifica("le_a5_valor", ref_mem[8'h10], 8'hA5);
      verifica("cont_lei_1", ContLeituras, 1);

      le(8'h10, 5);
      verifica("cont_lei_2", ContLeituras, 2);
      verifica("cont_esc_ign", ContEscritas, 1);

      for (int i = 0; i < 260; i++) begin
         a = i[7:0];
         d = a ^ 8'h5A;
         armazena(a, d, 1'b0);
      end
      verifica("sat_esc", ContEscritas, 255);
      armazena(8'h40, 8'h99, 1'b1);
      verifica("zera_esc", ContEscritas, 0);
      verifica("zera_lei", ContLeituras, 0);
      le(8'h03, 0);
      verifica("cont_lei_pos_zera", ContLeituras, 1);

      armazena(8'h20, 8'h00, 1'b0);
      ReqValido = 1'b1; ReqEscrita = 1'b1; ReqEndereco = 8'h20; ReqDado = 8'h77;
      @(posedge Clock); #1;
      ReqValido = 1'b0;
      verifica("abort_escmem", EscMem, 1);
      #2 Reset_n = 1'b0;
      #1;
      verifica("abort_escmem_0", EscMem, 0);
      verifica("abort_contesc", ContEscritas, 0);
      verifica("abort_contlei", ContLeituras, 0);
      verifica("abort_end", Endereco, 0);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      verifica("abort_pronto", ReqPronto, 1);
      le(8'h20, 0);
      verifica("abort_lei", ContLeituras, 1);
      verifica("abort_esc", ContEscritas, 0);

      for (int i = 0; i < 30; i++) begin
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         armazena(a, d, 1'b0);
         if (i % 2 == 0) le(a, 0);
         else            le(8'($urandom_range(0, 255)), 0);
      end
      verifica("alt_contesc", ContEscritas, 30);
      verifica("alt_contlei", ContLeituras, 31);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
